// File: rtl/mem_access_responder.sv
// Line-granular memory responder: same-cycle ack with serials, fixed-latency
// in-order read results and write completions over a line-addressed array.
package mem_access_responder_pkg;
  localparam int PHY_ADDR_WIDTH                 = 32;
  localparam int DCACHE_LINE_BIT_WIDTH          = 64;
  localparam int DCACHE_LINE_BYTE_NUM_BIT_WIDTH = 3;
  localparam int MSHR_NUM                       = 2;
  localparam int MEM_ACCESS_SERIAL_BIT_SIZE     = 2;
  localparam int MEM_WRITE_SERIAL_BIT_SIZE      = 1;

  typedef struct packed {
    logic                             valid;
    logic                             we;
    logic [PHY_ADDR_WIDTH-1:0]        addr;
    logic [DCACHE_LINE_BIT_WIDTH-1:0] data;
  } MemAccessReq;

  typedef struct packed {
    logic                                  ack;
    logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] serial;
    logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0]  wserial;
  } MemAccessReqAck;

  typedef struct packed {
    logic                                  valid;
    logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] serial;
    logic [DCACHE_LINE_BIT_WIDTH-1:0]      data;
  } MemAccessResult;

  typedef struct packed {
    logic                                 valid;
    logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0] serial;
  } MemAccessResponse;
endpackage

module mem_access_responder
  import mem_access_responder_pkg::*;
#(
  parameter int MEM_LINE_NUM      = 1024,
  parameter int READ_LATENCY      = 4,
  parameter int WRITE_LATENCY     = 2,
  parameter int READ_OUTSTANDING  = MSHR_NUM + 1,
  parameter int WRITE_OUTSTANDING = MSHR_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  MemAccessReq      memAccessReq,
  output MemAccessReqAck   memReqAck,
  output MemAccessResult   memAccessResult,
  output MemAccessResponse memAccessResponse
);
  localparam int IDXW = $clog2(MEM_LINE_NUM);
  localparam int OFFW = DCACHE_LINE_BYTE_NUM_BIT_WIDTH;
  localparam int DW   = DCACHE_LINE_BIT_WIDTH;
  localparam int RSW  = MEM_ACCESS_SERIAL_BIT_SIZE;
  localparam int WSW  = MEM_WRITE_SERIAL_BIT_SIZE;
  localparam int RCW  = $clog2(READ_OUTSTANDING + 1);
  localparam int WCW  = $clog2(WRITE_OUTSTANDING + 1);

  localparam logic [RSW-1:0] RdLast = RSW'(READ_OUTSTANDING - 1);
  localparam logic [WSW-1:0] WrLast = WSW'(WRITE_OUTSTANDING - 1);
  localparam logic [RCW-1:0] RdMax  = RCW'(READ_OUTSTANDING);
  localparam logic [WCW-1:0] WrMax  = WCW'(WRITE_OUTSTANDING);
  localparam logic [3:0]     RdInit = 4'(READ_LATENCY - 1);
  localparam logic [3:0]     WrInit = 4'(WRITE_LATENCY - 1);

  logic [DW-1:0] mem_q [MEM_LINE_NUM];

  // In-flight slots are indexed by serial: in-order retirement makes the
  // oldest serial the queue head and the current serial counter the tail.
  logic [READ_OUTSTANDING-1:0]  rdValid_q, rdValid_d;
  logic [3:0]                   rdCnt_q [READ_OUTSTANDING];
  logic [3:0]                   rdCnt_d [READ_OUTSTANDING];
  logic [DW-1:0]                rdData_q [READ_OUTSTANDING];
  logic [RSW-1:0]               rdHead_q, rdHead_d, rdTail_q, rdTail_d;
  logic [RCW-1:0]               rdCount_q, rdCount_d;

  logic [WRITE_OUTSTANDING-1:0] wrValid_q, wrValid_d;
  logic [3:0]                   wrCnt_q [WRITE_OUTSTANDING];
  logic [3:0]                   wrCnt_d [WRITE_OUTSTANDING];
  logic [WSW-1:0]               wrHead_q, wrHead_d, wrTail_q, wrTail_d;
  logic [WCW-1:0]               wrCount_q, wrCount_d;

  logic            readRetiring, writeRetiring, readAck, writeAck;
  logic [IDXW-1:0] lineIdx;
  logic            unusedAddrBits;

  function automatic logic [RSW-1:0] rdNext(input logic [RSW-1:0] s);
    return (s == RdLast) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [WSW-1:0] wrNext(input logic [WSW-1:0] s);
    return (s == WrLast) ? '0 : s + 1'b1;
  endfunction

  assign lineIdx        = memAccessReq.addr[OFFW +: IDXW];
  assign unusedAddrBits = ^{memAccessReq.addr[PHY_ADDR_WIDTH-1:OFFW+IDXW],
                            memAccessReq.addr[OFFW-1:0]};

  assign readRetiring  = rdValid_q[rdHead_q] && (rdCnt_q[rdHead_q] == 4'd0);
  assign writeRetiring = wrValid_q[wrHead_q] && (wrCnt_q[wrHead_q] == 4'd0);

  // Gated by rst so nothing is acked while reset is held.
  assign readAck  = rst && memAccessReq.valid && !memAccessReq.we &&
                    ((rdCount_q < RdMax) || readRetiring);
  assign writeAck = rst && memAccessReq.valid && memAccessReq.we &&
                    ((wrCount_q < WrMax) || writeRetiring);

  always_comb begin
    rdValid_d = rdValid_q;
    rdHead_d  = rdHead_q;
    rdTail_d  = rdTail_q;
    rdCount_d = rdCount_q;
    for (int i = 0; i < READ_OUTSTANDING; i++)
      rdCnt_d[i] = (rdCnt_q[i] != 4'd0) ? rdCnt_q[i] - 4'd1 : rdCnt_q[i];
    // Retire before accept so a freed head slot can be refilled this cycle.
    if (readRetiring) begin
      rdValid_d[rdHead_q] = 1'b0;
      rdHead_d            = rdNext(rdHead_q);
    end
    if (readAck) begin
      rdValid_d[rdTail_q] = 1'b1;
      rdCnt_d[rdTail_q]   = RdInit;
      rdTail_d            = rdNext(rdTail_q);
    end
    case ({readAck, readRetiring})
      2'b10:   rdCount_d = rdCount_q + 1'b1;
      2'b01:   rdCount_d = rdCount_q - 1'b1;
      default: rdCount_d = rdCount_q;
    endcase

    wrValid_d = wrValid_q;
    wrHead_d  = wrHead_q;
    wrTail_d  = wrTail_q;
    wrCount_d = wrCount_q;
    for (int i = 0; i < WRITE_OUTSTANDING; i++)
      wrCnt_d[i] = (wrCnt_q[i] != 4'd0) ? wrCnt_q[i] - 4'd1 : wrCnt_q[i];
    if (writeRetiring) begin
      wrValid_d[wrHead_q] = 1'b0;
      wrHead_d            = wrNext(wrHead_q);
    end
    if (writeAck) begin
      wrValid_d[wrTail_q] = 1'b1;
      wrCnt_d[wrTail_q]   = WrInit;
      wrTail_d            = wrNext(wrTail_q);
    end
    case ({writeAck, writeRetiring})
      2'b10:   wrCount_d = wrCount_q + 1'b1;
      2'b01:   wrCount_d = wrCount_q - 1'b1;
      default: wrCount_d = wrCount_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdValid_q <= '0;
      rdHead_q  <= '0;
      rdTail_q  <= '0;
      rdCount_q <= '0;
      wrValid_q <= '0;
      wrHead_q  <= '0;
      wrTail_q  <= '0;
      wrCount_q <= '0;
      for (int i = 0; i < READ_OUTSTANDING; i++)  rdCnt_q[i] <= '0;
      for (int i = 0; i < WRITE_OUTSTANDING; i++) wrCnt_q[i] <= '0;
    end else begin
      rdValid_q <= rdValid_d;
      rdHead_q  <= rdHead_d;
      rdTail_q  <= rdTail_d;
      rdCount_q <= rdCount_d;
      wrValid_q <= wrValid_d;
      wrHead_q  <= wrHead_d;
      wrTail_q  <= wrTail_d;
      wrCount_q <= wrCount_d;
      for (int i = 0; i < READ_OUTSTANDING; i++)  rdCnt_q[i] <= rdCnt_d[i];
      for (int i = 0; i < WRITE_OUTSTANDING; i++) wrCnt_q[i] <= wrCnt_d[i];
    end
  end

  // Backing array and captured read data are intentionally not reset.
  always_ff @(posedge clk) begin
    if (writeAck) mem_q[lineIdx] <= memAccessReq.data;
    if (readAck)  rdData_q[rdTail_q] <= mem_q[lineIdx];
  end

  always_comb begin
    memReqAck         = '0;
    memAccessResult   = '0;
    memAccessResponse = '0;
    memReqAck.ack     = readAck || writeAck;
    if (readAck)  memReqAck.serial  = rdTail_q;
    if (writeAck) memReqAck.wserial = wrTail_q;
    if (readRetiring) begin
      memAccessResult.valid  = 1'b1;
      memAccessResult.serial = rdHead_q;
      memAccessResult.data   = rdData_q[rdHead_q];
    end
    if (writeRetiring) begin
      memAccessResponse.valid  = 1'b1;
      memAccessResponse.serial = wrHead_q;
    end
  end
endmodule

// File: tb/tb_mem_access_responder.sv
// Bench for mem_access_responder: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a due-time queue model.
module tb_mem_access_responder;
  import mem_access_responder_pkg::*;

  localparam int LINES   = 1024;
  localparam int RD_LAT  = 4;
  localparam int WR_LAT  = 2;
  localparam int RD_OUT  = 3;
  localparam int WR_OUT  = 2;

  typedef struct {
    int          due;
    int          serial;
    logic [63:0] data;
    bit          known;
  } RdEntry;

  typedef struct {
    int due;
    int serial;
  } WrEntry;

  logic             clk = 1'b0;
  logic             rst;
  MemAccessReq      req;
  MemAccessReqAck   ackOut;
  MemAccessResult   resOut;
  MemAccessResponse respOut;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  RdEntry      rdQ[$];
  WrEntry      wrQ[$];
  logic [63:0] memModel [int];
  int          rdSerial = 0;
  int          wrSerial = 0;

  mem_access_responder dut (
    .clk              (clk),
    .rst              (rst),
    .memAccessReq     (req),
    .memReqAck        (ackOut),
    .memAccessResult  (resOut),
    .memAccessResponse(respOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [31:0] addr,
                               input logic [63:0] data);
    @(posedge clk);
    #1;
    req.valid = v;
    req.we    = we;
    req.addr  = addr;
    req.data  = data;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Reference model: every transaction carries the cycle it is due; the
  // outstanding limit is judged on queue length after this cycle's retirement.
  always @(negedge clk) begin
    bit          expResV, expRespV, rdAck, wrAck;
    int          idx;
    RdEntry      re;
    WrEntry      we;
    if (!rst) begin
      rdQ.delete();
      wrQ.delete();
      rdSerial = 0;
      wrSerial = 0;
      checkOutput("ack", 64'(ackOut), 64'd0);
      checkOutput("result", 64'(resOut.valid), 64'd0);
      checkOutput("response", 64'(respOut), 64'd0);
    end else begin
      expResV  = (rdQ.size() > 0) && (rdQ[0].due == cyc);
      expRespV = (wrQ.size() > 0) && (wrQ[0].due == cyc);
      rdAck = req.valid && !req.we && ((rdQ.size() - int'(expResV)) < RD_OUT);
      wrAck = req.valid &&  req.we && ((wrQ.size() - int'(expRespV)) < WR_OUT);
      idx   = int'((req.addr >> 3) % LINES);

      checkOutput("ack", 64'(ackOut.ack), 64'(rdAck || wrAck));
      checkOutput("ackSerial", 64'(ackOut.serial), rdAck ? 64'(rdSerial) : 64'd0);
      checkOutput("ackWserial", 64'(ackOut.wserial), wrAck ? 64'(wrSerial) : 64'd0);
      checkOutput("resValid", 64'(resOut.valid), 64'(expResV));
      checkOutput("resSerial", 64'(resOut.serial), expResV ? 64'(rdQ[0].serial) : 64'd0);
      if (!expResV)
        checkOutput("resData", resOut.data, 64'd0);
      else if (rdQ[0].known)
        checkOutput("resData", resOut.data, rdQ[0].data);
      checkOutput("respValid", 64'(respOut.valid), 64'(expRespV));
      checkOutput("respSerial", 64'(respOut.serial), expRespV ? 64'(wrQ[0].serial) : 64'd0);

      if (expResV)  void'(rdQ.pop_front());
      if (expRespV) void'(wrQ.pop_front());
      if (rdAck) begin
        re.due    = cyc + RD_LAT;
        re.serial = rdSerial;
        re.known  = memModel.exists(idx);
        re.data   = re.known ? memModel[idx] : 64'd0;
        rdQ.push_back(re);
        rdSerial = (rdSerial + 1) % RD_OUT;
      end
      if (wrAck) begin
        memModel[idx] = req.data;
        we.due    = cyc + WR_LAT;
        we.serial = wrSerial;
        wrQ.push_back(we);
        wrSerial = (wrSerial + 1) % WR_OUT;
      end
    end
    cyc++;
  end

  initial begin
    logic [31:0] addr;
    rst = 1'b0;
    req = '0;

    // Reset held with a live request.
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 64'h0);
      @(negedge clk);
      checkOutput("lit rstAck", 64'(ackOut.ack), 64'd0);
      checkOutput("lit rstRes", 64'(resOut.valid), 64'd0);
      checkOutput("lit rstResp", 64'(respOut.valid), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;

    // Write then read back.
    applyStimulus(1'b1, 1'b1, 32'h100, 64'h1122334455667788);
    @(negedge clk);
    checkOutput("lit wrAck", 64'({ackOut.ack, ackOut.wserial}), 64'b10);
    applyStimulus(1'b1, 1'b0, 32'h100, 64'h0);
    @(negedge clk);
    checkOutput("lit rdAck", 64'({ackOut.ack, ackOut.serial}), 64'b100);
    checkOutput("lit respEarly", 64'(respOut.valid), 64'd0);
    idle(1);
    @(negedge clk);
    checkOutput("lit resp", 64'({respOut.valid, respOut.serial}), 64'b10);
    idle(1);
    @(negedge clk);
    checkOutput("lit respOnce", 64'(respOut.valid), 64'd0);
    idle(1);
    @(negedge clk);
    checkOutput("lit resEarly", 64'(resOut.valid), 64'd0);
    idle(1);
    @(negedge clk);
    checkOutput("lit resValid", 64'(resOut.valid), 64'd1);
    checkOutput("lit resData", resOut.data, 64'h1122334455667788);
    idle(2);

    // Read outstanding limit.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(i * 8), 64'h0);
      @(negedge clk);
      if (i < 3) checkOutput("lit rdFullAck", 64'({ackOut.ack, ackOut.serial}), 64'(4 + i));
      else       checkOutput("lit rdFullNack", 64'(ackOut.ack), 64'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h18, 64'h0);
    @(negedge clk);
    checkOutput("lit rdReuseAck", 64'({ackOut.ack, ackOut.serial}), 64'b100);
    checkOutput("lit rdReuseRes", 64'({resOut.valid, resOut.serial}), 64'b100);
    idle(3);
    @(negedge clk);
    checkOutput("lit rdGap", 64'(resOut.valid), 64'd0);
    idle(1);
    @(negedge clk);
    checkOutput("lit rd4thRes", 64'({resOut.valid, resOut.serial}), 64'b100);
    idle(2);

    // Write outstanding limit; also fills lines 0..2 for later reads.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i * 8), {$urandom, $urandom});
      @(negedge clk);
      checkOutput("lit wrFullAck", 64'({ackOut.ack, ackOut.wserial}), 64'({1'b1, i[0] & (i < 2)}));
    end
    checkOutput("lit wrFullResp", 64'({respOut.valid, respOut.serial}), 64'b10);
    idle(4);

    // Aliasing across MEM_LINE_NUM lines and byte offset.
    applyStimulus(1'b1, 1'b1, 32'h8, 64'hAAAA00005555FFFF);
    applyStimulus(1'b1, 1'b0, 32'(8 + LINES * 8 + 3), 64'h0);
    idle(4);
    @(negedge clk);
    checkOutput("lit aliasData", resOut.data, 64'hAAAA00005555FFFF);
    idle(2);

    // Reset with reads in flight.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 64'h0);
    applyStimulus(1'b1, 1'b0, 32'h8, 64'h0);
    doReset();
    repeat (6) begin
      idle(1);
      @(negedge clk);
      checkOutput("lit flushRes", 64'(resOut.valid), 64'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h10, 64'h0);
    @(negedge clk);
    checkOutput("lit postRstRd", 64'({ackOut.ack, ackOut.serial}), 64'b100);
    applyStimulus(1'b1, 1'b1, 32'h18, 64'h0123456789ABCDEF);
    @(negedge clk);
    checkOutput("lit postRstWr", 64'({ackOut.ack, ackOut.wserial}), 64'b10);

    // Randomized traffic over a few lines with aliasing and rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        doReset();
      end else begin
        addr = 32'($urandom_range(0, 7) * 8 + $urandom_range(0, 3) * LINES * 8 +
                   $urandom_range(0, 7));
        applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, addr,
                      {$urandom, $urandom});
      end
    end
    idle(8);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
